// File: rtl/fetch_queue.sv
// Decoupling queue between fetch and decode: a DEPTH-entry circular buffer of
// {instruction, PC, PC+4} with one-cycle fall-through and full back-pressure.
module fetch_queue #(
   parameter int DATA_WIDTH = 32,
   parameter int DEPTH      = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [DATA_WIDTH-1:0]    InstrF,
   input  logic [DATA_WIDTH-1:0]    PCF,
   input  logic [DATA_WIDTH-1:0]    PCPlus4F,
   input  logic                     ValidF,
   input  logic                     FlushD,
   input  logic                     StallD,
   output logic [DATA_WIDTH-1:0]    InstrD,
   output logic [DATA_WIDTH-1:0]    PCD,
   output logic [DATA_WIDTH-1:0]    PCPlus4D,
   output logic                     ValidD,
   output logic                     FullF,
   output logic [$clog2(DEPTH):0]   Count
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam logic [PTR_W:0]          FULL_CNT = DEPTH[PTR_W:0];
   localparam logic [DATA_WIDTH-1:0]   NOP      = DATA_WIDTH'(32'h0000_0013);

   logic [DATA_WIDTH-1:0] instr_mem [DEPTH];
   logic [DATA_WIDTH-1:0] pc_mem    [DEPTH];
   logic [DATA_WIDTH-1:0] pc4_mem   [DEPTH];

   logic [PTR_W-1:0] rd_ptr;
   logic [PTR_W-1:0] wr_ptr;
   logic             push;
   logic             pop;

   assign ValidD = (Count != '0);
   assign FullF  = (Count == FULL_CNT);

   // Full refuses a push even when a pop frees a slot the same cycle.
   assign push = ValidF && !FullF && !FlushD;
   assign pop  = ValidD && !StallD && !FlushD;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         Count  <= '0;
      end else if (FlushD) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         Count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + PTR_W'(1);
         if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
         case ({push, pop})
            2'b10:   Count <= Count + (PTR_W+1)'(1);
            2'b01:   Count <= Count - (PTR_W+1)'(1);
            default: Count <= Count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         instr_mem[wr_ptr] <= InstrF;
         pc_mem[wr_ptr]    <= PCF;
         pc4_mem[wr_ptr]   <= PCPlus4F;
      end
   end

   // Empty queue presents a NOP bubble to decode.
   always_comb begin
      InstrD   = NOP;
      PCD      = '0;
      PCPlus4D = '0;
      if (ValidD) begin
         InstrD   = instr_mem[rd_ptr];
         PCD      = pc_mem[rd_ptr];
         PCPlus4D = pc4_mem[rd_ptr];
      end
   end

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue: fall-through, back-pressure, flush priority,
// wrap-around ordering and asynchronous reset.
module tb_fetch_queue;

   logic        clk;
   logic        rst;
   logic [31:0] InstrF;
   logic [31:0] PCF;
   logic [31:0] PCPlus4F;
   logic        ValidF;
   logic        FlushD;
   logic        StallD;
   logic [31:0] InstrD;
   logic [31:0] PCD;
   logic [31:0] PCPlus4D;
   logic        ValidD;
   logic        FullF;
   logic [2:0]  Count;

   int vectors;
   int miscompares;

   fetch_queue #(.DATA_WIDTH(32), .DEPTH(4)) dut (
      .clk(clk), .rst(rst),
      .InstrF(InstrF), .PCF(PCF), .PCPlus4F(PCPlus4F), .ValidF(ValidF),
      .FlushD(FlushD), .StallD(StallD),
      .InstrD(InstrD), .PCD(PCD), .PCPlus4D(PCPlus4D),
      .ValidD(ValidD), .FullF(FullF), .Count(Count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp)
      else begin
         miscompares++;
         $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic fetch(input logic v, input logic [31:0] pc, input logic [31:0] instr);
      ValidF   = v;
      PCF      = pc;
      PCPlus4F = pc + 32'd4;
      InstrF   = instr;
   endtask

   initial begin
      int in_idx;
      int out_idx;
      vectors     = 0;
      miscompares = 0;
      rst    = 1'b1;
      FlushD = 1'b0;
      StallD = 1'b0;
      fetch(1'b0, 32'h0, 32'h0);

      // Reset state
      #1 rst = 1'b0;
      #1;
      check("rst_validd", 32'(ValidD), 32'd0);
      check("rst_fullf", 32'(FullF), 32'd0);
      check("rst_count", 32'(Count), 32'd0);
      check("rst_instrd", InstrD, 32'h0000_0013);
      check("rst_pcd", PCD, 32'h0);
      check("rst_pc4d", PCPlus4D, 32'h0);
      @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      #1;

      // Fall-through
      fetch(1'b1, 32'h0, 32'h0050_0093);
      tick();
      fetch(1'b0, 32'h0, 32'h0);
      check("ft_validd", 32'(ValidD), 32'd1);
      check("ft_pcd", PCD, 32'h0);
      check("ft_pc4d", PCPlus4D, 32'h4);
      check("ft_instrd", InstrD, 32'h0050_0093);
      check("ft_count", 32'(Count), 32'd1);
      tick();
      check("ft_pop_validd", 32'(ValidD), 32'd0);
      check("ft_pop_instrd", InstrD, 32'h0000_0013);
      check("ft_pop_count", 32'(Count), 32'd0);

      // Fill under stall, then refused fifth push
      StallD = 1'b1;
      for (int i = 0; i < 4; i++) begin
         fetch(1'b1, 32'(i * 4), 32'h1000 + 32'(i));
         tick();
      end
      check("fill_count", 32'(Count), 32'd4);
      check("fill_fullf", 32'(FullF), 32'd1);
      check("fill_head", PCD, 32'h0);
      fetch(1'b1, 32'h10, 32'h1004);
      tick();
      check("refuse_count", 32'(Count), 32'd4);
      check("refuse_head", PCD, 32'h0);

      // Full with simultaneous pop: pop happens, push refused
      StallD = 1'b0;
      tick();
      fetch(1'b0, 32'h0, 32'h0);
      StallD = 1'b1;
      check("fullpop_count", 32'(Count), 32'd3);
      check("fullpop_fullf", 32'(FullF), 32'd0);
      check("fullpop_head", PCD, 32'h4);
      check("fullpop_instr", InstrD, 32'h1001);

      // Flush with 3 entries and a fetch presented
      FlushD = 1'b1;
      StallD = 1'b0;
      fetch(1'b1, 32'h40, 32'h2000);
      tick();
      FlushD = 1'b0;
      StallD = 1'b1;
      fetch(1'b0, 32'h0, 32'h0);
      check("flush_count", 32'(Count), 32'd0);
      check("flush_validd", 32'(ValidD), 32'd0);
      check("flush_instrd", InstrD, 32'h0000_0013);
      tick();
      check("flush_dropped", 32'(Count), 32'd0);

      // Flush from full
      for (int i = 0; i < 4; i++) begin
         fetch(1'b1, 32'h80 + 32'(i * 4), 32'h3000 + 32'(i));
         tick();
      end
      check("full2_fullf", 32'(FullF), 32'd1);
      FlushD = 1'b1;
      fetch(1'b0, 32'h0, 32'h0);
      tick();
      FlushD = 1'b0;
      check("flushfull_fullf", 32'(FullF), 32'd0);
      check("flushfull_validd", 32'(ValidD), 32'd0);

      // Streaming with StallD toggling every 2 cycles; exercises pointer wrap
      in_idx  = 0;
      out_idx = 0;
      for (int c = 0; c < 80 && out_idx < 10; c++) begin
         StallD = ((c / 2) % 2) == 1;
         fetch(in_idx < 10, 32'(in_idx * 4), 32'h4000 + 32'(in_idx));
         if (ValidD && !StallD) begin
            check("stream_pcd", PCD, 32'(out_idx * 4));
            check("stream_instrd", InstrD, 32'h4000 + 32'(out_idx));
            out_idx++;
         end
         if (ValidF && !FullF) in_idx++;
         tick();
      end
      fetch(1'b0, 32'h0, 32'h0);
      check("stream_popped", 32'(out_idx), 32'd10);
      check("stream_empty", 32'(ValidD), 32'd0);

      // Asynchronous reset mid-operation
      StallD = 1'b1;
      fetch(1'b1, 32'h200, 32'h5000);
      tick();
      fetch(1'b1, 32'h204, 32'h5001);
      tick();
      fetch(1'b0, 32'h0, 32'h0);
      check("ar_count_pre", 32'(Count), 32'd2);
      #2 rst = 1'b0;
      #1;
      check("ar_validd", 32'(ValidD), 32'd0);
      check("ar_count", 32'(Count), 32'd0);
      check("ar_instrd", InstrD, 32'h0000_0013);
      @(negedge clk);
      rst    = 1'b1;
      StallD = 1'b0;
      fetch(1'b1, 32'h100, 32'h6000);
      tick();
      fetch(1'b0, 32'h0, 32'h0);
      check("ar_push_pcd", PCD, 32'h100);
      check("ar_push_validd", 32'(ValidD), 32'd1);
      check("ar_push_count", 32'(Count), 32'd1);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
